ies_control_unit: RTL and testbench
===================================

Name: ies_control_unit

Overview:
- Multicycle control FSM that sequences the instruction execution system.
- Decodes the 4-bit opcode returned by the IES and drives every IES control strobe for the current state.
- Also drives fetch/PC/memory enables and counts retired instructions.
- Sits between the memory/PC logic and the IES datapath; one instruction is in flight at a time.

Parameters:
- RETIRE_W, 16, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  4  opcode from IES, valid from DECODE onward.
- cmp_result  in  1  IES compare result, combinational in the cycle cmpeq/cmpne is asserted.
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN).
- irWrite, pcWrite  out  1  load IR / load PC.
- pcSrc  out  2  0=PC+1, 1=branch target (ALUout), 2=jump imm (ImR), 3=RAOut.
- memRead, memWrite  out  1  data/instruction memory strobes.
- backup, restore, writeCR, cmpeq, cmpne, RegR1, RegR2, RegW1, RegW2, ALUsrc  out  1  IES controls.
- Regsrc  out  2  0=ALUout, 1=w2_1 (memory), 2=ioIn, 3=ImR.
- ALUop  out  3  0=add, 1=sub, 2=and, 3=or, 4=slt; 5-7 unused, driven 0.
- halted  out  1  high while in HALT.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs are a Moore decode of state plus registered opcode `opq`, except pcWrite in EXEC for branches, which also depends on cmp_result.
- Reset:
  - state=FETCH, opq=0, retired=0.
  - All outputs 0 in the reset cycle.
  - Reset asserted in any state aborts the instruction with no partial PC/register/memory write that cycle.
- FETCH:
  - memRead=1, irWrite=1, pcWrite=1, pcSrc=0.
  - Goes to DECODE.
- DECODE:
  - RegR1=1, RegR2=1, opq<=op.
  - Next state: HALT if op=F, else EXEC.
- Opcodes and the EXEC / later-state actions:
  - 0 add, 1 sub, 2 and, 3 or: EXEC ALUop per op, ALUsrc=0 -> WB with RegW1=1, Regsrc=0.
  - 4 addi: EXEC ALUsrc=1, ALUop=0 -> WB with RegW1, Regsrc=0.
  - 5 slt: EXEC ALUop=4, writeCR=1 (latches AltB) -> FETCH.
  - 6 lw: EXEC add with imm -> MEM (memRead) -> WB with RegW2=1, Regsrc=1.
  - 7 sw: EXEC add with imm -> MEM (memWrite) -> FETCH.
  - 8 beq / 9 bne: EXEC cmpeq (or cmpne)=1, pcSrc=1, pcWrite=cmp_result -> FETCH.
  - A j: EXEC pcSrc=2, pcWrite=1 -> FETCH.
  - B jal: EXEC backup=1, pcSrc=2, pcWrite=1 -> FETCH.
  - C jr: EXEC restore=1, pcSrc=3, pcWrite=1 -> FETCH.
  - D in: EXEC -> WB with RegW1, Regsrc=2.
  - E out: EXEC RegR1 held, ioOut path active -> FETCH.
  - F halt: goes to HALT.
- Latencies in cycles:
  - 3: slt, sw-less paths (branches, jumps, jal, jr, out).
  - 4: R-type, addi, in, sw.
  - 5: lw.
- `retired` increments by 1 on every transition into FETCH from EXEC, MEM or WB. It wraps to 0 past all-ones.
- HALT: halted=1 and all strobes 0. Left only by reset.
- Each IES strobe is asserted exactly in the listed states; never two of backup/restore/writeCR in the same cycle.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: FETCH and MEM hold state, keeping their strobes asserted, until mem_ready=1.
  - irWrite and pcWrite in FETCH are gated by mem_ready.
  - A stalled cycle does not increment `retired`.
- Undefined: mem_ready is ignored and every memory access completes in one cycle.

Test Plan:
- Reset then add (op=0): state sequence FETCH, DECODE, EXEC (ALUop=0, ALUsrc=0), WB (RegW1=1, Regsrc=0), FETCH. `retired` goes 0->1.
- beq with cmp_result=1 then a second beq with cmp_result=0:
  - First: EXEC shows cmpeq=1, pcSrc=1, pcWrite=1.
  - Second: pcWrite=0.
  - Both return to FETCH after 3 cycles.
- lw: 5-cycle sequence; MEM has memRead=1; WB has RegW2=1, Regsrc=1.
- jal then jr:
  - jal EXEC: backup=1, pcSrc=2.
  - jr EXEC: restore=1, pcSrc=3, pcWrite=1.
  - No other strobes asserted in either cycle.
- halt (op=F): halted=1 and strobes 0 for 10 cycles; reset returns to FETCH with retired=0. Reset asserted mid-WB of addi: RegW1 low in that cycle.
- MEM_WAIT_EN, sw with mem_ready low for 3 cycles:
  - memWrite held for 4 cycles, then FETCH.
  - `retired` increments once.

Source files
------------

// File: rtl/ies_control_unit.sv
// ies_control_unit: multicycle control FSM for the instruction execution system.
// Sequences FETCH/DECODE/EXEC/MEM/WB/HALT, decodes the registered opcode into
// IES strobes, drives PC/memory enables and counts retired instructions.
// Optional macro MEM_WAIT_EN: FETCH and MEM stall until mem_ready is high.
module ies_control_unit #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          op,
  input  logic                cmp_result,
  input  logic                mem_ready,
  output logic                irWrite,
  output logic                pcWrite,
  output logic [1:0]          pcSrc,
  output logic                memRead,
  output logic                memWrite,
  output logic                backup,
  output logic                restore,
  output logic                writeCR,
  output logic                cmpeq,
  output logic                cmpne,
  output logic                RegR1,
  output logic                RegR2,
  output logic                RegW1,
  output logic                RegW2,
  output logic                ALUsrc,
  output logic [1:0]          Regsrc,
  output logic [2:0]          ALUop,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_JR   = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state;
  state_t              next_state;
  logic [3:0]          opq;
  logic [RETIRE_W-1:0] retired_q;
  logic                mem_done;
  logic                retire;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // An instruction retires whenever control returns to FETCH from a later state.
  assign retire = (next_state == FETCH) &&
                  ((state == EXEC) || (state == MEM) || (state == WB));

  // Reset forces every output low in the reset cycle so nothing partial is written.
  assign retired = reset ? '0 : retired_q;

  // State register, opcode latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      opq       <= 4'h0;
      retired_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        opq <= op;
      end
      if (retire) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  // Next-state and Moore strobe decode; everything stays low while reset is high.
  always_comb begin
    next_state = state;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'd0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    backup     = 1'b0;
    restore    = 1'b0;
    writeCR    = 1'b0;
    cmpeq      = 1'b0;
    cmpne      = 1'b0;
    RegR1      = 1'b0;
    RegR2      = 1'b0;
    RegW1      = 1'b0;
    RegW2      = 1'b0;
    ALUsrc     = 1'b0;
    Regsrc     = 2'd0;
    ALUop      = 3'd0;
    halted     = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          memRead = 1'b1;
          irWrite = mem_done;
          pcWrite = mem_done;
          pcSrc   = 2'd0;
          if (mem_done) begin
            next_state = DECODE;
          end
        end
        DECODE: begin
          RegR1      = 1'b1;
          RegR2      = 1'b1;
          next_state = (op == OP_HALT) ? HALT : EXEC;
        end
        EXEC: begin
          case (opq)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              ALUop      = {1'b0, opq[1:0]};
              next_state = WB;
            end
            OP_ADDI: begin
              ALUsrc     = 1'b1;
              next_state = WB;
            end
            OP_SLT: begin
              ALUop      = 3'd4;
              writeCR    = 1'b1;
              next_state = FETCH;
            end
            OP_LW, OP_SW: begin
              ALUsrc     = 1'b1;
              next_state = MEM;
            end
            OP_BEQ, OP_BNE: begin
              cmpeq      = (opq == OP_BEQ);
              cmpne      = (opq == OP_BNE);
              pcSrc      = 2'd1;
              pcWrite    = cmp_result;
              next_state = FETCH;
            end
            OP_J: begin
              pcSrc      = 2'd2;
              pcWrite    = 1'b1;
              next_state = FETCH;
            end
            OP_JAL: begin
              backup     = 1'b1;
              pcSrc      = 2'd2;
              pcWrite    = 1'b1;
              next_state = FETCH;
            end
            OP_JR: begin
              restore    = 1'b1;
              pcSrc      = 2'd3;
              pcWrite    = 1'b1;
              next_state = FETCH;
            end
            OP_IN: begin
              next_state = WB;
            end
            OP_OUT: begin
              RegR1      = 1'b1;
              next_state = FETCH;
            end
            default: begin
              next_state = HALT;
            end
          endcase
        end
        MEM: begin
          memRead  = (opq == OP_LW);
          memWrite = (opq == OP_SW);
          if (mem_done) begin
            next_state = (opq == OP_LW) ? WB : FETCH;
          end
        end
        WB: begin
          if (opq == OP_LW) begin
            RegW2  = 1'b1;
            Regsrc = 2'd1;
          end else if (opq == OP_IN) begin
            RegW1  = 1'b1;
            Regsrc = 2'd2;
          end else begin
            RegW1  = 1'b1;
            Regsrc = 2'd0;
          end
          next_state = FETCH;
        end
        HALT: begin
          halted     = 1'b1;
          next_state = HALT;
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ies_control_unit.sv
// tb_ies_control_unit: directed-vector bench for ies_control_unit.
// Each cycle the full strobe vector is compared against hand-built constants.
module tb_ies_control_unit;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    op;
  logic          cmp_result;
  logic          mem_ready;
  logic          irWrite, pcWrite, memRead, memWrite;
  logic [1:0]    pcSrc, Regsrc;
  logic          backup, restore, writeCR, cmpeq, cmpne;
  logic          RegR1, RegR2, RegW1, RegW2, ALUsrc, halted;
  logic [2:0]    ALUop;
  logic [RW-1:0] retired;

  int testsRun    = 0;
  int testsFailed = 0;
  int expRet      = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  ies_control_unit #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .op(op), .cmp_result(cmp_result), .mem_ready(mem_ready),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .memRead(memRead),
    .memWrite(memWrite), .backup(backup), .restore(restore), .writeCR(writeCR),
    .cmpeq(cmpeq), .cmpne(cmpne), .RegR1(RegR1), .RegR2(RegR2), .RegW1(RegW1),
    .RegW2(RegW2), .ALUsrc(ALUsrc), .Regsrc(Regsrc), .ALUop(ALUop),
    .halted(halted), .retired(retired)
  );

  wire [21:0] obs = {irWrite, pcWrite, pcSrc, memRead, memWrite, backup, restore,
                     writeCR, cmpeq, cmpne, RegR1, RegR2, RegW1, RegW2, ALUsrc,
                     Regsrc, ALUop, halted};

  localparam logic [21:0] IRW   = 22'd1 << 21;
  localparam logic [21:0] PCW   = 22'd1 << 20;
  localparam logic [21:0] PS1   = 22'd1 << 18;
  localparam logic [21:0] PS2   = 22'd2 << 18;
  localparam logic [21:0] PS3   = 22'd3 << 18;
  localparam logic [21:0] MR    = 22'd1 << 17;
  localparam logic [21:0] MW    = 22'd1 << 16;
  localparam logic [21:0] BK    = 22'd1 << 15;
  localparam logic [21:0] RS    = 22'd1 << 14;
  localparam logic [21:0] WCR   = 22'd1 << 13;
  localparam logic [21:0] CEQ   = 22'd1 << 12;
  localparam logic [21:0] CNE   = 22'd1 << 11;
  localparam logic [21:0] R1    = 22'd1 << 10;
  localparam logic [21:0] R2    = 22'd1 << 9;
  localparam logic [21:0] W1    = 22'd1 << 8;
  localparam logic [21:0] W2    = 22'd1 << 7;
  localparam logic [21:0] ASRC  = 22'd1 << 6;
  localparam logic [21:0] RSRC1 = 22'd1 << 4;
  localparam logic [21:0] RSRC2 = 22'd2 << 4;
  localparam logic [21:0] AOP1  = 22'd1 << 1;
  localparam logic [21:0] AOP4  = 22'd4 << 1;
  localparam logic [21:0] HLT   = 22'd1;

  localparam logic [21:0] V_ZERO     = 22'd0;
  localparam logic [21:0] V_FETCH    = IRW | PCW | MR;
  localparam logic [21:0] V_DEC      = R1 | R2;
  localparam logic [21:0] V_EX_ADD   = 22'd0;
  localparam logic [21:0] V_EX_SUB   = AOP1;
  localparam logic [21:0] V_WB_R     = W1;
  localparam logic [21:0] V_EX_BEQ_T = PCW | PS1 | CEQ;
  localparam logic [21:0] V_EX_BEQ_F = PS1 | CEQ;
  localparam logic [21:0] V_EX_BNE_T = PCW | PS1 | CNE;
  localparam logic [21:0] V_EX_LW    = ASRC;
  localparam logic [21:0] V_MEM_LW   = MR;
  localparam logic [21:0] V_WB_LW    = W2 | RSRC1;
  localparam logic [21:0] V_EX_SW    = ASRC;
  localparam logic [21:0] V_MEM_SW   = MW;
  localparam logic [21:0] V_EX_J     = PCW | PS2;
  localparam logic [21:0] V_EX_JAL   = PCW | PS2 | BK;
  localparam logic [21:0] V_EX_JR    = PCW | PS3 | RS;
  localparam logic [21:0] V_EX_SLT   = AOP4 | WCR;
  localparam logic [21:0] V_EX_ADDI  = ASRC;
  localparam logic [21:0] V_EX_IN    = 22'd0;
  localparam logic [21:0] V_WB_IN    = W1 | RSRC2;
  localparam logic [21:0] V_EX_OUT   = R1;
  localparam logic [21:0] V_HALT     = HLT;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting at its FETCH negedge; ends at the next FETCH negedge.
  task automatic applyStimulus(input string name, input logic [3:0] opc, input logic cmp,
                               input int n, input logic [21:0] e1, input logic [21:0] e2,
                               input logic [21:0] e3, input logic [21:0] e4);
    logic [21:0] ev [4];
    ev[0] = e1; ev[1] = e2; ev[2] = e3; ev[3] = e4;
    op = opc;
    cmp_result = cmp;
    #1;
    checkOutput({name, " fetch"}, {10'd0, obs}, {10'd0, V_FETCH});
    for (int c = 0; c < n - 1; c++) begin
      @(negedge clk);
      checkOutput($sformatf("%s c%0d", name, c + 1), {10'd0, obs}, {10'd0, ev[c]});
    end
    @(negedge clk);
    expRet = (expRet + 1) % (1 << RW);
    checkOutput({name, " retired"}, {28'd0, retired}, expRet);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; op = 4'h0; cmp_result = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("reset outputs", {10'd0, obs}, {10'd0, V_ZERO});
    checkOutput("reset retired", {28'd0, retired}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("add",    4'h0, 1'b0, 4, V_DEC, V_EX_ADD,   V_WB_R,   V_ZERO);
    applyStimulus("beq_t",  4'h8, 1'b1, 3, V_DEC, V_EX_BEQ_T, V_ZERO,   V_ZERO);
    applyStimulus("beq_f",  4'h8, 1'b0, 3, V_DEC, V_EX_BEQ_F, V_ZERO,   V_ZERO);
    applyStimulus("lw",     4'h6, 1'b0, 5, V_DEC, V_EX_LW,    V_MEM_LW, V_WB_LW);
    applyStimulus("jal",    4'hB, 1'b0, 3, V_DEC, V_EX_JAL,   V_ZERO,   V_ZERO);
    applyStimulus("jr",     4'hC, 1'b0, 3, V_DEC, V_EX_JR,    V_ZERO,   V_ZERO);
    applyStimulus("sub",    4'h1, 1'b0, 4, V_DEC, V_EX_SUB,   V_WB_R,   V_ZERO);
    applyStimulus("slt",    4'h5, 1'b1, 3, V_DEC, V_EX_SLT,   V_ZERO,   V_ZERO);
    applyStimulus("addi",   4'h4, 1'b0, 4, V_DEC, V_EX_ADDI,  V_WB_R,   V_ZERO);
    applyStimulus("in",     4'hD, 1'b0, 4, V_DEC, V_EX_IN,    V_WB_IN,  V_ZERO);
    applyStimulus("out",    4'hE, 1'b0, 3, V_DEC, V_EX_OUT,   V_ZERO,   V_ZERO);
    applyStimulus("bne_t",  4'h9, 1'b1, 3, V_DEC, V_EX_BNE_T, V_ZERO,   V_ZERO);

    // halt: stays halted with all strobes low until reset
    op = 4'hF; #1;
    checkOutput("halt fetch", {10'd0, obs}, {10'd0, V_FETCH});
    @(negedge clk);
    checkOutput("halt decode", {10'd0, obs}, {10'd0, V_DEC});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("halt c%0d", i), {10'd0, obs}, {10'd0, V_HALT});
    end
    checkOutput("halt retired", {28'd0, retired}, expRet);
    reset = 1'b1; #1;
    checkOutput("halt reset outputs", {10'd0, obs}, {10'd0, V_ZERO});
    @(negedge clk);
    reset = 1'b0; expRet = 0; #1;
    checkOutput("post-halt fetch", {10'd0, obs}, {10'd0, V_FETCH});
    checkOutput("post-halt retired", {28'd0, retired}, 32'd0);

    // reset during WB of addi suppresses the register write and the retire
    applyStimulus("add0", 4'h0, 1'b0, 4, V_DEC, V_EX_ADD, V_WB_R, V_ZERO);
    op = 4'h4; #1;
    checkOutput("rwb fetch", {10'd0, obs}, {10'd0, V_FETCH});
    @(negedge clk);
    checkOutput("rwb decode", {10'd0, obs}, {10'd0, V_DEC});
    @(negedge clk);
    checkOutput("rwb exec", {10'd0, obs}, {10'd0, V_EX_ADDI});
    @(negedge clk);
    checkOutput("rwb wb", {10'd0, obs}, {10'd0, V_WB_R});
    reset = 1'b1; #1;
    checkOutput("rwb RegW1", {31'd0, RegW1}, 32'd0);
    checkOutput("rwb outputs", {10'd0, obs}, {10'd0, V_ZERO});
    @(negedge clk);
    reset = 1'b0; expRet = 0; #1;
    checkOutput("rwb retired", {28'd0, retired}, 32'd0);

    // 16 jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("j%0d", i), 4'hA, 1'b0, 3, V_DEC, V_EX_J, V_ZERO, V_ZERO);
    end
    checkOutput("wrap retired", {28'd0, retired}, 32'd0);

`ifdef MEM_WAIT_EN
    op = 4'h7; mem_ready = 1'b0; #1;
    checkOutput("stall fetch", {10'd0, obs}, {10'd0, MR});
    @(negedge clk);
    checkOutput("stall fetch hold", {10'd0, obs}, {10'd0, MR});
    mem_ready = 1'b1; #1;
    checkOutput("ready fetch", {10'd0, obs}, {10'd0, V_FETCH});
    @(negedge clk);
    checkOutput("sw decode", {10'd0, obs}, {10'd0, V_DEC});
    @(negedge clk);
    checkOutput("sw exec", {10'd0, obs}, {10'd0, V_EX_SW});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sw stall %0d", i), {10'd0, obs}, {10'd0, V_MEM_SW});
      checkOutput($sformatf("sw stall ret %0d", i), {28'd0, retired}, expRet);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("sw mem last", {10'd0, obs}, {10'd0, V_MEM_SW});
    @(negedge clk);
    expRet = (expRet + 1) % (1 << RW);
    checkOutput("sw fetch", {10'd0, obs}, {10'd0, V_FETCH});
    checkOutput("sw retired", {28'd0, retired}, expRet);
`else
    mem_ready = 1'b0;
    applyStimulus("sw_nowait", 4'h7, 1'b0, 4, V_DEC, V_EX_SW, V_MEM_SW, V_ZERO);
    applyStimulus("lw_nowait", 4'h6, 1'b0, 5, V_DEC, V_EX_LW, V_MEM_LW, V_WB_LW);
    mem_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
